// File: rtl/tdm_demux16.sv
// Serial-to-parallel 16-lane TDM demultiplexer with a valid/ready frame output.
// Define TDM_DEMUX_PARITY_EN to add an even-parity slot and the parity_err output.
module tdm_demux16 #(
  parameter int LANES = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [LANES-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef TDM_DEMUX_PARITY_EN
  output logic [SEL_W:0]   sel,
  output logic             parity_err,
`else
  output logic [SEL_W-1:0] sel,
`endif
  output logic             overrun
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME = LANES + 1;
  localparam int CNT_W = SEL_W + 1;
`else
  localparam int FRAME = LANES;
  localparam int CNT_W = SEL_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0] r_sel;
  logic [LANES-1:0] r_asm;
  logic [LANES-1:0] r_out;
  logic             r_out_valid;
  logic             r_overrun;

  logic [CNT_W-1:0] w_sel_nxt;
  logic [LANES-1:0] w_asm_nxt;
  logic [LANES-1:0] w_frame;
  logic             w_done;
  logic             w_load;

  always_comb begin
    w_sel_nxt = r_sel;
    w_asm_nxt = r_asm;
    w_frame   = '0;
    w_done    = 1'b0;
    if (sync) begin
      // Realign: the current bit (if any) becomes slot 0.
      w_asm_nxt    = '0;
      w_asm_nxt[0] = in & in_valid;
      w_sel_nxt    = in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_sel == CNT_W'(k)) w_asm_nxt[k] = in;
      end
      if (r_sel == LAST) begin
        w_done    = 1'b1;
        w_frame   = w_asm_nxt;
        w_asm_nxt = '0;
        w_sel_nxt = '0;
      end else begin
        w_sel_nxt = r_sel + CNT_W'(1);
      end
    end
  end

  assign w_load = w_done & (~r_out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_asm       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_asm     <= w_asm_nxt;
      r_overrun <= w_done & ~w_load;
      if (w_load) begin
        r_out       <= w_frame;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= ^r_asm ^ in;
    end
  end

  assign parity_err = r_perr;
`endif

  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized bench for tdm_demux16 against a slot/array reference model.
// Also builds with TDM_DEMUX_PARITY_EN defined (parity slot checks).
module tb_tdm_demux16;

  localparam int LANES = 16;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FLEN = LANES + 1;
  localparam int SW   = 5;
`else
  localparam int FLEN = LANES;
  localparam int SW   = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic             sync = 1'b0;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] out;
  logic             out_valid;
  logic [SW-1:0]    sel;
  logic             overrun;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_err;
`endif

  tdm_demux16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .sync      (sync),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ovr_cnt = 0;
  int ov_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  int          m_slot;
  bit          m_bits[LANES];
  bit [LANES-1:0] m_out;
  bit          m_ov, m_ovr, m_perr;

  task automatic m_reset();
    m_slot = 0;
    foreach (m_bits[i]) m_bits[i] = 1'b0;
    m_out  = '0;
    m_ov   = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic m_edge(input bit v, input bit b, input bit s, input bit r);
    bit             done;
    bit [LANES-1:0] fr;
    bit             pe;
    done  = 1'b0;
    fr    = '0;
    pe    = 1'b0;
    m_ovr = 1'b0;
    if (s) begin
      foreach (m_bits[i]) m_bits[i] = 1'b0;
      if (v) begin
        m_bits[0] = b;
        m_slot = 1;
      end else begin
        m_slot = 0;
      end
    end else if (v) begin
      if (m_slot < LANES) m_bits[m_slot] = b;
      if (m_slot == FLEN - 1) begin
        done = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          fr[i] = m_bits[i];
          pe ^= m_bits[i];
          m_bits[i] = 1'b0;
        end
        if (FLEN > LANES) pe ^= b;
        m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    if (done) begin
      if (!m_ov || r) begin
        m_out  = fr;
        m_ov   = 1'b1;
        m_perr = pe;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_ov && r) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic cyc(input bit v, input bit b, input bit s, input bit r);
    in_valid  = v;
    in        = b;
    sync      = s;
    out_ready = r;
    @(posedge clk);
    m_edge(v, b, s, r);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("sel", 32'(sel), 32'(m_slot));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef TDM_DEMUX_PARITY_EN
    if (m_ov) chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    if (overrun) ovr_cnt++;
    if (out_valid) ov_cnt++;
  endtask

  task automatic send_raw(input logic [LANES-1:0] w, input int gap,
                          input bit r, input bit pbit);
    for (int k = 0; k < LANES; k++) begin
      while ($urandom_range(99) < gap) cyc(1'b0, 1'($urandom), 1'b0, r);
      cyc(1'b1, w[k], 1'b0, r);
    end
`ifdef TDM_DEMUX_PARITY_EN
    chk("sel_par", 32'(sel), 32'(LANES));
    cyc(1'b1, pbit, 1'b0, r);
`endif
  endtask

  task automatic send_frame(input logic [LANES-1:0] w, input int gap,
                            input bit r);
    send_raw(w, gap, r, ^w);
  endtask

  initial begin
    int ov0, ovr0;
    m_reset();
    #12;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < LANES; k++) begin
      send_frame(LANES'(1) << k, 0, 1'b1);
      chk("walk", 32'(out), 32'(1) << k);
      chk("walk_v", 32'(out_valid), 32'h1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    send_frame(16'hA5C3, 40, 1'b1);
    chk("gapped", 32'(out), 32'hA5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    ovr0 = ovr_cnt;
    send_frame(16'h1234, 0, 1'b0);
    send_frame(16'hFFFF, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold", 32'(out), 32'h1234);
    chk("bp_ovr", 32'(ovr_cnt - ovr0), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_drain", 32'(out_valid), 32'h0);

    ov0 = ov_cnt;
    ovr0 = ovr_cnt;
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sync_sel", 32'(sel), 32'h1);
    for (int k = 1; k < LANES; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
`endif
    chk("sync_once", 32'(ov_cnt - ov0), 32'h1);
    chk("sync_out", 32'(out), 32'h0001);
    chk("sync_ovr", 32'(ovr_cnt - ovr0), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
    send_raw(16'h0003, 0, 1'b1, 1'b0);
    chk("par_ok", 32'(parity_err), 32'h0);
    send_raw(16'h0007, 0, 1'b1, 1'b0);
    chk("par_err", 32'(parity_err), 32'h1);
`endif

    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(99) < 75), 1'($urandom),
          1'($urandom_range(99) < 3), 1'($urandom_range(99) < 60));
    end

    // Asynchronous reset between edges, sampled before any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(16'hBEEF, 20, 1'b1);
    chk("post_rst", 32'(out), 32'hBEEF);
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(99) < 90), 1'($urandom),
          1'($urandom_range(99) < 2), 1'($urandom_range(99) < 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
